// File: rtl/heap_arb_pkg.sv
// Shared types and constants for the heap arbiter slice.
package heap_arb_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/heap_arbiter_if.sv
// Requester-side bus of the heap arbiter: request vectors in, one-hot ack and response out.
interface heap_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_op;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;

    modport master (
        output req_valid, req_op, req_data,
        input  req_ack, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_data,
        output req_ack, rsp_data, rsp_err
    );

endinterface

// File: rtl/heap_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             any_req_c
);

    always_comb begin
        int unsigned pos;
        logic        found;
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        pos       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                gnt_c[pos] = 1'b1;
                gnt_idx_c  = IDX_W'(pos);
            end
        end
    end

    assign any_req_c = |req;

endmodule

// File: rtl/heap_arbiter.sv
// Round-robin arbiter sharing one heap between NUM_REQ push/pop requesters.
// Optional HEAP_ARB_TIMEOUT_EN adds a WAIT watchdog and a sticky timeout_flag output.
module heap_arbiter
    import heap_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_W      = 8
`ifdef HEAP_ARB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    heap_arbiter_if.slave     req_if,
    output logic              heap_push,
    output logic              heap_pop,
    output logic [DATA_W-1:0] heap_din,
    input  logic [DATA_W-1:0] heap_dout,
    input  logic              heap_empty,
    input  logic              heap_full,
    input  logic              heap_busy
`ifdef HEAP_ARB_TIMEOUT_EN
    , output logic            timeout_flag
`endif
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   grant, grant_d;
    logic               op_q, op_d;
    logic               wait_seen, wait_seen_d;
    logic [NUM_REQ-1:0] ack_d;
    logic [DATA_W-1:0]  rsp_data_d;
    logic               rsp_err_d;
    logic               push_d, pop_d;
    logic [DATA_W-1:0]  din_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               sel_op;
    logic [DATA_W-1:0]  sel_data;

`ifdef HEAP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
    logic             tflag_d;
`endif

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req       (req_if.req_valid),
        .ptr       (ptr),
        .gnt_c     (arb_gnt),
        .gnt_idx_c (arb_idx),
        .any_req_c (arb_any)
    );

    assign sel_op   = req_if.req_op[arb_idx];
    assign sel_data = req_if.req_data[32'(arb_idx) * DATA_W +: DATA_W];

    // Next-state and next-output logic; outputs are registered from the *_d values.
    always_comb begin
        state_d     = state;
        ptr_d       = ptr;
        grant_d     = grant;
        op_d        = op_q;
        wait_seen_d = wait_seen;
        ack_d       = '0;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        push_d      = 1'b0;
        pop_d       = 1'b0;
        din_d       = heap_din;
`ifdef HEAP_ARB_TIMEOUT_EN
        wait_cnt_d  = wait_cnt;
        tflag_d     = timeout_flag;
`endif
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_idx;
                    op_d    = sel_op;
                    // Reject without touching the heap when the op cannot succeed.
                    if ((sel_op == OP_PUSH && heap_full) || (sel_op == OP_POP && heap_empty)) begin
                        state_d   = RESP;
                        ack_d     = arb_gnt;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        push_d  = (sel_op == OP_PUSH);
                        pop_d   = (sel_op == OP_POP);
                        din_d   = sel_data;
                    end
                end
            end
            ISSUE: begin
                state_d     = WAIT;
                wait_seen_d = 1'b0;
`ifdef HEAP_ARB_TIMEOUT_EN
                wait_cnt_d  = '0;
`endif
            end
            WAIT: begin
                // heap_busy is not yet meaningful in the first WAIT cycle.
                wait_seen_d = 1'b1;
`ifdef HEAP_ARB_TIMEOUT_EN
                if (wait_cnt != CNT_W'(TIMEOUT_CYC))
                    wait_cnt_d = wait_cnt + 1'b1;
`endif
                if (wait_seen && !heap_busy) begin
                    state_d    = RESP;
                    ack_d      = NUM_REQ'(1) << grant;
                    rsp_data_d = (op_q == OP_POP) ? heap_dout : '0;
                end
`ifdef HEAP_ARB_TIMEOUT_EN
                else if (heap_busy && wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = RESP;
                    ack_d     = NUM_REQ'(1) << grant;
                    rsp_err_d = 1'b1;
                    tflag_d   = 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            ptr              <= '0;
            grant            <= '0;
            op_q             <= OP_PUSH;
            wait_seen        <= 1'b0;
            req_if.req_ack   <= '0;
            req_if.rsp_data  <= '0;
            req_if.rsp_err   <= 1'b0;
            heap_push        <= 1'b0;
            heap_pop         <= 1'b0;
            heap_din         <= '0;
        end else begin
            state            <= state_d;
            ptr              <= ptr_d;
            grant            <= grant_d;
            op_q             <= op_d;
            wait_seen        <= wait_seen_d;
            req_if.req_ack   <= ack_d;
            req_if.rsp_data  <= rsp_data_d;
            req_if.rsp_err   <= rsp_err_d;
            heap_push        <= push_d;
            heap_pop         <= pop_d;
            heap_din         <= din_d;
        end
    end

`ifdef HEAP_ARB_TIMEOUT_EN
    // Watchdog counter and sticky flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wait_cnt     <= wait_cnt_d;
            timeout_flag <= tflag_d;
        end
    end
`endif

endmodule

// File: tb/tb_heap_arbiter.sv
// Directed bench for heap_arbiter with a small behavioural min-heap stub.
module tb_heap_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_W   = 8;
    localparam int          CAP      = 4;
    localparam int          BUSY_LEN = 3;
    localparam int          LAT_OK   = 6;
    localparam int          LAT_REJ  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    heap_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) rif ();

    logic              heap_push, heap_pop;
    logic [DATA_W-1:0] heap_din, heap_dout;
    logic              heap_empty, heap_full, heap_busy;
`ifdef HEAP_ARB_TIMEOUT_EN
    logic              timeout_flag;
`endif

    heap_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
`ifdef HEAP_ARB_TIMEOUT_EN
        , .TIMEOUT_CYC (8)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_if     (rif),
        .heap_push  (heap_push),
        .heap_pop   (heap_pop),
        .heap_din   (heap_din),
        .heap_dout  (heap_dout),
        .heap_empty (heap_empty),
        .heap_full  (heap_full),
        .heap_busy  (heap_busy)
`ifdef HEAP_ARB_TIMEOUT_EN
        , .timeout_flag (timeout_flag)
`endif
    );

    // Heap stub: unsorted store, pop returns the minimum, busy for BUSY_LEN cycles per op.
    logic [7:0] mem [CAP];
    int         h_cnt;
    int         busy_cnt;
    logic       stuck_busy = 1'b0;
    int         bad_strobe = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h_cnt     <= 0;
            busy_cnt  <= 0;
            heap_dout <= '0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (heap_push) begin
                if (h_cnt == CAP) bad_strobe = bad_strobe + 1;
                else begin
                    mem[h_cnt] <= heap_din;
                    h_cnt      <= h_cnt + 1;
                end
                busy_cnt <= BUSY_LEN;
            end
            if (heap_pop) begin
                if (h_cnt == 0) bad_strobe = bad_strobe + 1;
                else begin
                    int mi;
                    mi = 0;
                    for (int j = 1; j < h_cnt; j++)
                        if (mem[j] < mem[mi]) mi = j;
                    heap_dout    <= mem[mi];
                    mem[mi]      <= mem[h_cnt-1];
                    h_cnt        <= h_cnt - 1;
                end
                busy_cnt <= BUSY_LEN;
            end
        end
    end

    assign heap_busy  = stuck_busy || (busy_cnt != 0);
    assign heap_empty = (h_cnt == 0);
    assign heap_full  = (h_cnt == CAP);

    int push_cnt = 0;
    int pop_cnt  = 0;
    int ack_total = 0;
    always @(posedge clk) begin
        if (heap_push) push_cnt = push_cnt + 1;
        if (heap_pop)  pop_cnt  = pop_cnt + 1;
    end
    always @(negedge clk) if (|rif.req_ack) ack_total = ack_total + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input string name, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            lat = lat + 1;
            if (|rif.req_ack) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL %s_timeout: got no ack expected ack within 200 cycles", name);
        end
    endtask

    typedef struct {
        int         idx;
        logic       op;
        logic [7:0] val;
        logic [7:0] exp_data;
        logic       exp_err;
        bit         exp_strobe;
        int         exp_lat;
    } vec_t;

    task automatic apply_vec(input vec_t v, input string tag);
        int lat;
        bit ok;
        int p0, q0;
        p0 = push_cnt;
        q0 = pop_cnt;
        rif.req_data = '0;
        rif.req_data[v.idx*8 +: 8] = v.val;
        rif.req_op = '0;
        rif.req_op[v.idx] = v.op;
        rif.req_valid = '0;
        rif.req_valid[v.idx] = 1'b1;
        wait_ack(tag, lat, ok);
        if (ok) begin
            chk({tag, "_ack"}, 32'(rif.req_ack), 32'(1) << v.idx);
            chk({tag, "_data"}, 32'(rif.rsp_data), 32'(v.exp_data));
            chk({tag, "_err"}, 32'(rif.rsp_err), 32'(v.exp_err));
            chk({tag, "_lat"}, 32'(lat), 32'(v.exp_lat));
        end
        rif.req_valid = '0;
        @(negedge clk);
        chk({tag, "_ack_drop"}, 32'(rif.req_ack), 32'h0);
        chk({tag, "_push_n"}, 32'(push_cnt - p0), (v.exp_strobe && v.op == 1'b0) ? 32'd1 : 32'd0);
        chk({tag, "_pop_n"}, 32'(pop_cnt - q0), (v.exp_strobe && v.op == 1'b1) ? 32'd1 : 32'd0);
        @(negedge clk);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"}, 32'(rif.req_ack), 32'h0);
        chk({tag, "_rsp_data"}, 32'(rif.rsp_data), 32'h0);
        chk({tag, "_rsp_err"}, 32'(rif.rsp_err), 32'h0);
        chk({tag, "_push"}, 32'(heap_push), 32'h0);
        chk({tag, "_pop"}, 32'(heap_pop), 32'h0);
        chk({tag, "_din"}, 32'(heap_din), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [13];
        vec_t v;
        int   lat;
        bit   ok;
        int   acks0;
        logic [7:0] pop_exp [4];

        // idx, op, value, expected data, expected err, heap touched, latency
        vecs[0]  = '{0, 1'b0, 8'h2A, 8'h00, 1'b0, 1'b1, LAT_OK};
        vecs[1]  = '{0, 1'b1, 8'h00, 8'h2A, 1'b0, 1'b1, LAT_OK};
        vecs[2]  = '{1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, LAT_REJ};
        vecs[3]  = '{2, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, LAT_OK};
        vecs[4]  = '{3, 1'b0, 8'h20, 8'h00, 1'b0, 1'b1, LAT_OK};
        vecs[5]  = '{1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b1, LAT_OK};
        vecs[6]  = '{0, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, LAT_OK};
        vecs[7]  = '{2, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, LAT_REJ};
        vecs[8]  = '{1, 1'b1, 8'h00, 8'h10, 1'b0, 1'b1, LAT_OK};
        vecs[9]  = '{3, 1'b1, 8'h00, 8'h20, 1'b0, 1'b1, LAT_OK};
        vecs[10] = '{0, 1'b1, 8'h00, 8'h30, 1'b0, 1'b1, LAT_OK};
        vecs[11] = '{2, 1'b1, 8'h00, 8'h40, 1'b0, 1'b1, LAT_OK};
        vecs[12] = '{3, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, LAT_REJ};

        rif.req_valid = '0;
        rif.req_op    = '0;
        rif.req_data  = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
`ifdef HEAP_ARB_TIMEOUT_EN
        chk("reset_tflag", 32'(timeout_flag), 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++)
            apply_vec(vecs[i], $sformatf("v%0d", i));

        // Contention: all four push at once from pointer 0.
        rif.req_op    = 4'b0000;
        rif.req_data  = {8'h07, 8'h09, 8'h03, 8'h05};
        rif.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("cpush%0d", k), lat, ok);
            if (ok) begin
                chk($sformatf("cpush%0d_ack", k), 32'(rif.req_ack), 32'(1) << k);
                chk($sformatf("cpush%0d_err", k), 32'(rif.rsp_err), 32'h0);
            end
            rif.req_valid = rif.req_valid & ~rif.req_ack;
        end
        rif.req_valid = '0;
        repeat (2) @(negedge clk);

        pop_exp = '{8'h03, 8'h05, 8'h07, 8'h09};
        rif.req_op    = 4'b1111;
        rif.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack($sformatf("cpop%0d", k), lat, ok);
            if (ok) begin
                chk($sformatf("cpop%0d_ack", k), 32'(rif.req_ack), 32'(1) << k);
                chk($sformatf("cpop%0d_data", k), 32'(rif.rsp_data), 32'(pop_exp[k]));
                chk($sformatf("cpop%0d_err", k), 32'(rif.rsp_err), 32'h0);
            end
            rif.req_valid = rif.req_valid & ~rif.req_ack;
        end
        rif.req_valid = '0;
        repeat (2) @(negedge clk);

        // Reset while the arbiter sits in WAIT.
        rif.req_op    = 4'b0000;
        rif.req_data  = {8'h00, 8'h00, 8'h00, 8'h11};
        rif.req_valid = 4'b0001;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (heap_push) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstw_push_seen", 32'(ok), 32'h1);
        repeat (2) @(negedge clk);
        acks0 = ack_total;
        rst_n = 1'b0;
        rif.req_valid = '0;
        @(negedge clk);
        chk_outputs_zero("rstw");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rstw_no_ack", 32'(ack_total - acks0), 32'h0);

        v = '{2, 1'b0, 8'h42, 8'h00, 1'b0, 1'b1, LAT_OK};
        apply_vec(v, "post_rst_push");
        v = '{1, 1'b1, 8'h00, 8'h42, 1'b0, 1'b1, LAT_OK};
        apply_vec(v, "post_rst_pop");

`ifdef HEAP_ARB_TIMEOUT_EN
        // Heap stuck busy: watchdog ends WAIT after 8 cycles with an error ack.
        chk("to_flag_before", 32'(timeout_flag), 32'h0);
        stuck_busy = 1'b1;
        v = '{0, 1'b0, 8'h55, 8'h00, 1'b1, 1'b1, 10};
        apply_vec(v, "to_push");
        chk("to_flag_set", 32'(timeout_flag), 32'h1);
        stuck_busy = 1'b0;
        repeat (2) @(negedge clk);
        v = '{1, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, LAT_OK};
        apply_vec(v, "to_pop");
        chk("to_flag_sticky", 32'(timeout_flag), 32'h1);
`endif

        chk("heap_misuse", 32'(bad_strobe), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/heap_arbiter.md
Name: heap_arbiter

Overview:
- Shares one `heap` priority-queue instance between NUM_REQ independent requesters.
- Accepts push/pop requests and grants them round-robin, one at a time.
- For each grant: issues a single-cycle push or pop strobe to the heap, waits until the heap reports idle, then acks the requester. A pop ack carries the popped value.
- Sits between client blocks and the heap; it is the only driver of the heap's push, pop and data_in.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, heap element width.
- TIMEOUT_CYC, 64, watchdog limit in cycles. Used only with HEAP_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_op  in  NUM_REQ  per-requester op: 0 = push, 1 = pop.
- req_data  in  NUM_REQ*DATA_W  push values; requester i uses bits [i*DATA_W +: DATA_W].
- req_ack  out  NUM_REQ  one-hot, single-cycle completion pulse.
- rsp_data  out  DATA_W  popped value, valid while any req_ack bit is high.
- rsp_err  out  1  request rejected or aborted, valid while any req_ack bit is high.
- heap_push  out  1  push strobe to heap.
- heap_pop  out  1  pop strobe to heap.
- heap_din  out  DATA_W  heap data_in.
- heap_dout  in  DATA_W  heap data_out.
- heap_empty  in  1  heap empty flag.
- heap_full  in  1  heap full flag.
- heap_busy  in  1  high whenever the heap FSM is not in IDLE.

Behaviour:
- Reset values: req_ack = 0, rsp_data = 0, rsp_err = 0, heap_push = 0, heap_pop = 0, heap_din = 0, RR pointer = 0, state = IDLE.
- Requester handshake:
  - Requester holds req_valid, req_op and req_data stable until it sees its req_ack bit.
  - Requester deasserts req_valid in the cycle after the ack, or presents a new request.
  - Dropping req_valid before the ack is illegal; behaviour is undefined.
- State machine:
  - IDLE:
    - No valid request: stay in IDLE.
    - Otherwise the RR arbiter picks the first valid requester at or after the pointer. Latch the grant index, op and data.
    - Push while heap_full, or pop while heap_empty: go to RESP with err = 1; the heap is not touched.
    - Otherwise go to ISSUE.
  - ISSUE (1 cycle): drive heap_push or heap_pop = 1 and heap_din = latched data. Go to WAIT.
  - WAIT:
    - Strobes low.
    - heap_busy is ignored in the first WAIT cycle; the heap needs one cycle to leave IDLE.
    - From the second WAIT cycle on, heap_busy == 0 goes to RESP. For a pop, heap_dout is captured at that edge.
  - RESP (1 cycle):
    - req_ack[grant] = 1, rsp_data = captured value (0 for pushes), rsp_err as decided.
    - Pointer advances to (grant + 1) mod NUM_REQ.
    - Go to IDLE.
- Throughput and latency:
  - Minimum request-to-ack latency is 4 cycles (IDLE, ISSUE, WAIT×1, RESP) plus the heap busy time.
  - The earliest next grant is in the cycle after RESP.
  - A rejected request takes 2 cycles.
- Fairness: a requester with valid held waits at most NUM_REQ-1 other grants.
- Full/empty flags are sampled only in IDLE, at grant time. The heap never receives a push when full or a pop when empty.
- A requester that sees its ack and still holds req_valid is treated as a new request and competes normally.
- Reset mid-operation:
  - Next edge forces IDLE; strobes, acks and pointer return to reset values.
  - No ack is issued for an in-flight request. Requesters must also be reset.

Optional Feature:
HEAP_ARB_TIMEOUT_EN
- Defined:
  - A WAIT-cycle counter, cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC while heap_busy is still 1: go to RESP with rsp_err = 1 and rsp_data = 0.
  - Also adds output timeout_flag (1 bit). It is set at that event, sticky until reset, and 0 at reset.
- Not defined: no counter and no timeout_flag port; WAIT waits indefinitely.

Decomposition:
- Package heap_arb_pkg:
  - op encoding constants OP_PUSH = 0, OP_POP = 1.
  - state enum {IDLE, ISSUE, WAIT, RESP}.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, grant index, any_req.
  - Purely combinational; reused elsewhere.

Test Plan:
- Single requester: req0 pushes 8'h2A, then pops → ack after heap idle, rsp_data = 8'h2A, rsp_err = 0, exactly one heap_push and one heap_pop pulse.
- Contention: all 4 requesters push (values 5, 9, 3, 7) simultaneously from pointer 0 → acks in order 0, 1, 2, 3; then 4 pops return 3, 5, 7, 9 (min-heap order).
- Empty pop: pop with heap_empty = 1 → ack 2 cycles after grant, rsp_err = 1, heap_pop never asserted.
- Full push: fill to capacity, then one more push of 8'hFF → rsp_err = 1, heap_push not asserted, later pops never return the rejected 8'hFF.
- Reset mid-WAIT: assert rst_n = 0 for one cycle during WAIT → next cycle all outputs 0, state IDLE, no ack; after release a new push completes normally.
- Timeout (HEAP_ARB_TIMEOUT_EN, TIMEOUT_CYC = 8): stub heap holds heap_busy = 1 → ack with rsp_err = 1 after 8 WAIT cycles, timeout_flag = 1 and sticky.
